alu_issue_seq: RTL

Operand-issue and writeback sequencer sitting directly around the combinational 8-bit ALU. It accepts one ALU operation per valid/ready handshake, reads operands from a small internal register file, drives the ALU's A_bus/B_bus/F inputs, captures C/CF/ZF, and writes the result back to a destination register while updating a flag register. It is the register-transfer stage that feeds the ALU and consumes its outputs.

---
 rtl/alu_issue_pkg.sv | 30 +++
 rtl/alu_issue_seq_if.sv | 48 ++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_seq.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and sizing for the ALU operand-issue / writeback sequencer.
package alu_issue_pkg;

  localparam int DATA_W = 8;
  localparam int F_W    = 4;
  localparam int NREG   = 4;
  localparam int RA_W   = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [F_W-1:0]    f;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // B operand comes from the immediate field or the second register read port.
  function automatic logic [DATA_W-1:0] select_b(input instr_t instr,
                                                 input logic [DATA_W-1:0] rs2_val);
    return instr.use_imm ? instr.imm : rs2_val;
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Bundle of the op handshake, host load port, ALU buses and writeback outputs.
interface alu_issue_seq_if;
  import alu_issue_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [F_W-1:0]    op_f;
  logic [RA_W-1:0]   op_rd;
  logic [RA_W-1:0]   op_rs1;
  logic [RA_W-1:0]   op_rs2;
  logic              op_use_imm;
  logic [DATA_W-1:0] op_imm;

  logic              ld_en;
  logic [RA_W-1:0]   ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] A_bus;
  logic [DATA_W-1:0] B_bus;
  logic [F_W-1:0]    F;
  logic [DATA_W-1:0] C;
  logic              CF;
  logic              ZF;

  logic              res_valid;
  logic [RA_W-1:0]   res_rd;
  logic [DATA_W-1:0] res_data;
  logic              flag_cf;
  logic              flag_zf;

  // The master side is the host issuing ops together with the external ALU.
  modport master (
    output op_valid, op_f, op_rd, op_rs1, op_rs2, op_use_imm, op_imm,
    output ld_en, ld_addr, ld_data,
    output C, CF, ZF,
    input  op_ready, A_bus, B_bus, F,
    input  res_valid, res_rd, res_data, flag_cf, flag_zf
  );

  modport slave (
    input  op_valid, op_f, op_rd, op_rs1, op_rs2, op_use_imm, op_imm,
    input  ld_en, ld_addr, ld_data,
    input  C, CF, ZF,
    output op_ready, A_bus, B_bus, F,
    output res_valid, res_rd, res_data, flag_cf, flag_zf
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file: two async read ports, writeback and host write ports.
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RA_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Writeback beats a host load to the same entry; distinct entries both update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == RA_W'(i))) begin
          regs_q[i] <= wb_data;
        end else if (ld_en && (ld_addr == RA_W'(i))) begin
          regs_q[i] <= ld_data;
        end
      end
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer around an external combinational ALU:
// IDLE -> EXEC (drive ALU, capture result) -> WB (commit register and flags).
module alu_issue_seq
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_seq_if.slave  bus
);

  state_t            state_q;
  state_t            state_d;
  instr_t            instr_q;
  logic              op_ready_c;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] res_c_q;
  logic              res_cf_q;
  logic              res_zf_q;
  logic              flag_cf_q;
  logic              flag_zf_q;
  logic              in_exec;
  logic              in_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // op_ready depends only on state, so there is no op_valid -> op_ready path.
  always_comb begin
    state_d    = state_q;
    op_ready_c = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        op_ready_c = 1'b0;
        state_d    = WB;
      end
      WB: begin
        state_d = bus.op_valid ? EXEC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept  = bus.op_valid && op_ready_c;
  assign in_exec = (state_q == EXEC);
  assign in_wb   = (state_q == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q.f       <= bus.op_f;
      instr_q.rd      <= bus.op_rd;
      instr_q.rs1     <= bus.op_rs1;
      instr_q.rs2     <= bus.op_rs2;
      instr_q.use_imm <= bus.op_use_imm;
      instr_q.imm     <= bus.op_imm;
    end
  end

  // ALU outputs are only meaningful while we are driving its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_c_q  <= '0;
      res_cf_q <= 1'b0;
      res_zf_q <= 1'b0;
    end else if (in_exec) begin
      res_c_q  <= bus.C;
      res_cf_q <= bus.CF;
      res_zf_q <= bus.ZF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_cf_q <= 1'b0;
      flag_zf_q <= 1'b0;
    end else if (in_wb) begin
      flag_cf_q <= res_cf_q;
      flag_zf_q <= res_zf_q;
    end
  end

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (in_wb),
    .wb_addr   (instr_q.rd),
    .wb_data   (res_c_q),
    .ld_en     (bus.ld_en),
    .ld_addr   (bus.ld_addr),
    .ld_data   (bus.ld_data),
    .rd_addr_a (instr_q.rs1),
    .rd_data_a (rs1_val),
    .rd_addr_b (instr_q.rs2),
    .rd_data_b (rs2_val)
  );

  // ALU buses are forced to zero outside EXEC so the ALU sees a quiet input.
  assign bus.A_bus     = in_exec ? rs1_val : '0;
  assign bus.B_bus     = in_exec ? select_b(instr_q, rs2_val) : '0;
  assign bus.F         = in_exec ? instr_q.f : '0;
  assign bus.op_ready  = op_ready_c;
  assign bus.res_valid = in_wb;
  assign bus.res_rd    = in_wb ? instr_q.rd : '0;
  assign bus.res_data  = in_wb ? res_c_q : '0;
  assign bus.flag_cf   = flag_cf_q;
  assign bus.flag_zf   = flag_zf_q;

endmodule
